// File: rtl/ysyx_25060173_mem_arbiter.sv
// Shares the single memory port between IFU and LSU: round-robin grant,
// one outstanding transaction, response routing and response timeout.
module ysyx_25060173_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err,
  output logic        busy
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          grant_id_q, grant_id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;

  logic          pick_valid_c;
  logic          pick_lsu_c;
  logic          timeout_c;

  // Round-robin pick: on a tie, grant the requester not served last
  always_comb begin
    pick_valid_c = ifu_req_valid | lsu_req_valid;
    if (ifu_req_valid && lsu_req_valid) begin
      pick_lsu_c = (last_grant_q == GNT_IFU);
    end else begin
      pick_lsu_c = lsu_req_valid;
    end
  end

  assign timeout_c = (cnt_q == TO_LAST);

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_LSU;
      grant_id_q   <= GNT_IFU;
      cnt_q        <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  // Next-state, grant capture and timeout counter
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          state_d      = ST_REQ;
          last_grant_d = pick_lsu_c;
          grant_id_d   = pick_lsu_c;
          if (pick_lsu_c) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wstrb_d = lsu_wen ? lsu_wstrb : '0;
          end else begin
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end
      end
      ST_RESP: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_resp_valid || timeout_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: handshakes, memory request and response routing
  always_comb begin
    logic          rv;
    logic [DW-1:0] rd;
    logic          re;
    rv             = 1'b0;
    rd             = '0;
    re             = 1'b0;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    ifu_resp_err   = 1'b0;
    lsu_resp_valid = 1'b0;
    lsu_rdata      = '0;
    lsu_resp_err   = 1'b0;
    mem_req_valid  = 1'b0;
    mem_addr       = '0;
    mem_wen        = 1'b0;
    mem_wdata      = '0;
    mem_wstrb      = '0;
    busy           = 1'b0;
    if (!reset) begin
      mem_addr  = addr_q;
      mem_wen   = wen_q;
      mem_wdata = wdata_q;
      mem_wstrb = wstrb_q;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid_c) begin
            ifu_req_ready = ~pick_lsu_c;
            lsu_req_ready = pick_lsu_c;
          end
        end
        ST_REQ: begin
          mem_req_valid = 1'b1;
          busy          = 1'b1;
        end
        ST_RESP: begin
          busy = 1'b1;
          if (mem_resp_valid) begin
            rv = 1'b1;
            rd = wen_q ? '0 : mem_rdata;
            re = mem_resp_err;
          end else if (timeout_c) begin
            rv = 1'b1;
            re = 1'b1;
          end
        end
        default: busy = 1'b0;
      endcase
      if (grant_id_q == GNT_LSU) begin
        lsu_resp_valid = rv;
        lsu_rdata      = rd;
        lsu_resp_err   = re;
      end else begin
        ifu_resp_valid = rv;
        ifu_rdata      = rd;
        ifu_resp_err   = re;
      end
    end
  end

endmodule
